// File: rtl/mem_pkg.sv
// Shared types for the memory-bus arbiter: access sizes, FSM states, bus owner.
package mem_pkg;

  localparam int MEM_DW = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_acc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  // Zero/sign extend an already right-aligned load value to 32 bits.
  function automatic logic [MEM_DW-1:0] mem_extend(input logic [MEM_DW-1:0] v,
                                                   input logic [1:0]        acc,
                                                   input logic              sext);
    logic [MEM_DW-1:0] r;
    r = v;
    case (acc)
      BYTE:    r = {{24{sext & v[7]}},  v[7:0]};
      HALF:    r = {{16{sext & v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: byte enables, store replication,
// load shift/extend and misalignment detection. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]        off_i,
  input  logic [1:0]        acc_i,
  input  logic              sext_i,
  input  logic [MEM_DW-1:0] wdata_i,
  input  logic [MEM_DW-1:0] rdata_i,
  output logic [3:0]        be_o,
  output logic [MEM_DW-1:0] wdata_o,
  output logic [MEM_DW-1:0] rdata_o,
  output logic              misalign_o
);

  logic [MEM_DW-1:0] rshift;

  // Store side: byte enables, replicated write data and alignment check.
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    case (acc_i)
      BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      HALF: begin
        be_o       = 4'b0011 << {off_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = off_i[0];
      end
      WORD: begin
        misalign_o = (off_i != 2'b00);
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    rshift  = rdata_i >> {off_i, 3'b000};
    rdata_o = mem_extend(rshift, acc_i, sext_i);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port memory bus with one outstanding
// transaction (IDLE -> REQ -> RSP). Data-port lane steering lives in
// mem_lane_align. Optional MEM_ARB_ROUND_ROBIN_EN replaces the fixed
// data-over-fetch priority with last-granted-loses on ties.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [1:0]    d_acc_i,
  input  logic          d_sext_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_err_o,
  output logic          m_req_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [3:0]    m_be_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic          m_gnt_i,
  input  logic          m_rvalid_i,
  input  logic [DW-1:0] m_rdata_i
);

  arb_state_t    state_q, state_d;
  arb_owner_t    owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;   // full byte address; low bits steer the load
  logic [3:0]    be_q, be_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    acc_q, acc_d;
  logic          sext_q, sext_d;

  logic          arb_en, d_prio, sel_d, sel_if, rsp;
  logic [1:0]    la_off, la_acc;
  logic          la_sext, la_mis;
  logic [3:0]    la_be;
  logic [DW-1:0] la_wdata, la_rdata;

  // In IDLE the aligner sees the live data request; afterwards it sees the
  // registered copy so the response is steered by what was issued.
  always_comb begin
    if (state_q == IDLE) begin
      la_off  = d_addr_i[1:0];
      la_acc  = d_acc_i;
      la_sext = d_sext_i;
    end else begin
      la_off  = addr_q[1:0];
      la_acc  = acc_q;
      la_sext = sext_q;
    end
  end

  mem_lane_align u_align (
    .off_i      (la_off),
    .acc_i      (la_acc),
    .sext_i     (la_sext),
    .wdata_i    (d_wdata_i),
    .rdata_i    (m_rdata_i),
    .be_o       (la_be),
    .wdata_o    (la_wdata),
    .rdata_o    (la_rdata),
    .misalign_o (la_mis)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner_t last_q, last_d;

  // On a tie the port that was not granted last wins.
  always_comb begin
    d_prio = (last_q == OWN_IF);
    last_d = last_q;
    if (sel_d)       last_d = OWN_D;
    else if (sel_if) last_d = OWN_IF;
  end

  // Last-granted port; error grants count as grants.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) last_q <= OWN_IF;
    else         last_q <= last_d;
  end
`else
  assign d_prio = 1'b1;
`endif

  // Combinational arbitration; grants are masked while reset is held.
  always_comb begin
    arb_en = (state_q == IDLE) && rstn_i;
    sel_d  = arb_en && d_req_i && (!if_req_i || d_prio);
    sel_if = arb_en && if_req_i && !sel_d;
  end

  // Next-state and request capture for the single outstanding transaction.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    acc_d   = acc_q;
    sext_d  = sext_q;
    case (state_q)
      IDLE: begin
        if (sel_d && !la_mis) begin
          state_d = REQ;
          owner_d = OWN_D;
          we_d    = d_we_i;
          addr_d  = d_addr_i;
          be_d    = la_be;
          wdata_d = d_we_i ? la_wdata : '0;
          acc_d   = d_acc_i;
          sext_d  = d_sext_i;
        end else if (sel_if) begin
          state_d = REQ;
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = if_addr_i;
          be_d    = 4'b1111;
          wdata_d = '0;
          acc_d   = WORD;
          sext_d  = 1'b0;
        end
      end
      REQ: begin
        if (m_gnt_i) state_d = RSP;
      end
      RSP: begin
        if (m_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction registers; reset abandons anything in flight.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
      sext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      sext_q  <= sext_d;
    end
  end

  // Port-facing outputs; responses pass straight through from m_rvalid_i.
  always_comb begin
    rsp         = (state_q == RSP) && m_rvalid_i;
    if_gnt_o    = sel_if;
    d_gnt_o     = sel_d;
    d_err_o     = sel_d && la_mis;
    if_rvalid_o = rsp && (owner_q == OWN_IF);
    d_rvalid_o  = rsp && (owner_q == OWN_D);
    if_rdata_o  = if_rvalid_o ? m_rdata_i : '0;
    d_rdata_o   = (d_rvalid_o && !we_q) ? la_rdata : '0;
    m_req_o     = (state_q == REQ);
    m_we_o      = we_q;
    m_addr_o    = {addr_q[AW-1:2], 2'b00};
    m_be_o      = be_q;
    m_wdata_o   = wdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: tests push expected grants, memory
// requests and responses; a monitor pops and compares as the DUT presents them.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        if_req_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        d_req_i, d_we_i, d_sext_i, d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [1:0]  d_acc_i;
  logic        m_req_o, m_we_o, m_gnt_i, m_rvalid_i;
  logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
  logic [3:0]  m_be_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_acc_i(d_acc_i),
    .d_sext_i(d_sext_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_be_o(m_be_o),
    .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
    .m_rdata_i(m_rdata_i)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct packed {
    logic        port;   // 0 fetch, 1 data
    logic [31:0] data;
  } rsp_t;

  logic [1:0]  exp_gnt[$];   // {err, port}
  mreq_t       exp_mem[$];
  rsp_t        exp_rsp[$];
  logic [31:0] rd_q[$];

  int errors = 0, checks = 0;
  int cyc = 0, gnt_hold = 0, acc_cnt = 0;
  bit drop_rsp = 0, inject_rv = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // Memory model: grant after gnt_hold waiting cycles, respond the next cycle.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    m_gnt_i    = 1'b0;
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      m_rvalid_i = 1'b0;
      if (!rstn_i) begin
        m_gnt_i  = 1'b0;
        wait_cnt = 0;
      end else if (inject_rv) begin
        inject_rv  = 0;
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'hA5A5A5A5;
      end else if (m_gnt_i) begin
        m_gnt_i = 1'b0;
        if (!drop_rsp) begin
          m_rvalid_i = 1'b1;
          m_rdata_i  = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
        end
      end else if (m_req_o) begin
        if (wait_cnt >= gnt_hold) begin
          m_gnt_i  = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Monitor: compare grants, memory requests and responses against the queues.
  initial begin
    mreq_t      cur, prev, e;
    rsp_t       r;
    logic [1:0] g;
    bit         prev_v;
    int         gnt_cyc[2];
    prev_v = 0;
    gnt_cyc[0] = 0;
    gnt_cyc[1] = 0;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rstn_i) begin
        prev_v = 0;
        continue;
      end
      if (if_gnt_o || d_gnt_o) begin
        chk("gnt_exclusive", 160'(if_gnt_o & d_gnt_o), 160'(0));
        if (exp_gnt.size() == 0) bad("unexpected_gnt");
        else begin
          g = exp_gnt.pop_front();
          chk("gnt_port", 160'(d_gnt_o), 160'(g[0]));
          chk("gnt_err", 160'(d_err_o), 160'(g[1]));
        end
        gnt_cyc[d_gnt_o ? 1 : 0] = cyc;
      end else if (d_err_o) begin
        bad("err_without_gnt");
      end
      if (m_req_o) begin
        cur = '{we: m_we_o, addr: m_addr_o, be: m_be_o, wdata: m_wdata_o};
        if (prev_v) chk("m_fields_stable", 160'(cur), 160'(prev));
        if (m_gnt_i) begin
          acc_cnt++;
          prev_v = 0;
          if (exp_mem.size() == 0) bad("unexpected_m_req");
          else begin
            e = exp_mem.pop_front();
            if (!cur.we) cur.wdata = '0;
            chk("m_request", 160'(cur), 160'(e));
          end
        end else begin
          prev   = cur;
          prev_v = 1;
        end
      end else begin
        prev_v = 0;
      end
      if (if_rvalid_o || d_rvalid_o) begin
        chk("rvalid_exclusive", 160'(if_rvalid_o & d_rvalid_o), 160'(0));
        if (exp_rsp.size() == 0) bad("unexpected_rvalid");
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_port", 160'(d_rvalid_o), 160'(r.port));
          chk("rsp_data", 160'(d_rvalid_o ? d_rdata_o : if_rdata_o), 160'(r.data));
          chk("rsp_latency", 160'(cyc - gnt_cyc[d_rvalid_o ? 1 : 0]), 160'(2 + gnt_hold));
        end
      end
    end
  end

  task automatic req_if(input logic [31:0] a);
    bit got;
    got = 0;
    @(negedge clk_i);
    if_req_i  = 1'b1;
    if_addr_i = a;
    for (int i = 0; i < 200 && !got; i++) begin
      #2;
      if (if_gnt_o) got = 1;
      else @(negedge clk_i);
    end
    if (!got) bad("if_gnt_timeout");
    @(posedge clk_i);
    #1 if_req_i = 1'b0;
  endtask

  task automatic req_d(input logic we, input logic [31:0] a, input logic [1:0] acc,
                       input logic sext, input logic [31:0] wd);
    bit got;
    got = 0;
    @(negedge clk_i);
    d_req_i   = 1'b1;
    d_we_i    = we;
    d_addr_i  = a;
    d_acc_i   = acc;
    d_sext_i  = sext;
    d_wdata_i = wd;
    for (int i = 0; i < 200 && !got; i++) begin
      #2;
      if (d_gnt_o) got = 1;
      else @(negedge clk_i);
    end
    if (!got) bad("d_gnt_timeout");
    @(posedge clk_i);
    #1 d_req_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk_i);
      if (exp_gnt.size() == 0 && exp_mem.size() == 0 && exp_rsp.size() == 0) done = 1;
    end
    if (!done) bad("drain_timeout");
    repeat (2) @(negedge clk_i);
  endtask

  // One transaction's expectations: grant, memory request, response, memory data.
  task automatic expect_txn(input logic port, input mreq_t m, input logic [31:0] rdata,
                            input logic [31:0] rsp_data);
    exp_gnt.push_back({1'b0, port});
    exp_mem.push_back(m);
    exp_rsp.push_back('{port: port, data: rsp_data});
    rd_q.push_back(rdata);
  endtask

  function automatic logic [138:0] all_outs();
    return {if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
            m_req_o, m_we_o, m_addr_o, m_be_o, m_wdata_o};
  endfunction

  initial begin
    int start_acc;
    rstn_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_acc_i = '0; d_sext_i = 1'b0; d_wdata_i = '0;
    repeat (2) @(negedge clk_i);
    #1 chk("reset_outputs", 160'(all_outs()), 160'(0));
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Fetch only
    expect_txn(1'b0, '{we: 0, addr: 32'h100, be: 4'hF, wdata: 0}, 32'hDEADBEEF, 32'hDEADBEEF);
    req_if(32'h100);
    wait_idle();

    // Single tie: data first, fetch after the data response
    expect_txn(1'b1, '{we: 0, addr: 32'h10, be: 4'hF, wdata: 0}, 32'h11111111, 32'h11111111);
    expect_txn(1'b0, '{we: 0, addr: 32'h20, be: 4'hF, wdata: 0}, 32'h22222222, 32'h22222222);
    fork
      req_d(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      req_if(32'h20);
    join
    wait_idle();

    // Back-to-back ties: data re-requests while fetch is still waiting
    expect_txn(1'b1, '{we: 0, addr: 32'h30, be: 4'hF, wdata: 0}, 32'h33333333, 32'h33333333);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expect_txn(1'b0, '{we: 0, addr: 32'h40, be: 4'hF, wdata: 0}, 32'h44444444, 32'h44444444);
    expect_txn(1'b1, '{we: 0, addr: 32'h34, be: 4'hF, wdata: 0}, 32'h55555555, 32'h55555555);
`else
    expect_txn(1'b1, '{we: 0, addr: 32'h34, be: 4'hF, wdata: 0}, 32'h55555555, 32'h55555555);
    expect_txn(1'b0, '{we: 0, addr: 32'h40, be: 4'hF, wdata: 0}, 32'h44444444, 32'h44444444);
`endif
    fork
      begin
        req_d(1'b0, 32'h30, 2'd2, 1'b0, 32'h0);
        req_d(1'b0, 32'h34, 2'd2, 1'b0, 32'h0);
      end
      req_if(32'h40);
    join
    wait_idle();

    // Loads: lane shift and extension
    expect_txn(1'b1, '{we: 0, addr: 32'h200, be: 4'b1000, wdata: 0}, 32'h80112233, 32'hFFFFFF80);
    req_d(1'b0, 32'h203, 2'd0, 1'b1, 32'h0);
    expect_txn(1'b1, '{we: 0, addr: 32'h200, be: 4'b1000, wdata: 0}, 32'h80112233, 32'h00000080);
    req_d(1'b0, 32'h203, 2'd0, 1'b0, 32'h0);
    expect_txn(1'b1, '{we: 0, addr: 32'h200, be: 4'b0010, wdata: 0}, 32'h80112233, 32'h00000022);
    req_d(1'b0, 32'h201, 2'd0, 1'b1, 32'h0);
    expect_txn(1'b1, '{we: 0, addr: 32'h200, be: 4'b1100, wdata: 0}, 32'h80011234, 32'hFFFF8001);
    req_d(1'b0, 32'h202, 2'd1, 1'b1, 32'h0);
    expect_txn(1'b1, '{we: 0, addr: 32'h200, be: 4'b0011, wdata: 0}, 32'h1234F00D, 32'h0000F00D);
    req_d(1'b0, 32'h200, 2'd1, 1'b0, 32'h0);
    wait_idle();

    // Stores: replication, byte enables, ack with zero read data
    expect_txn(1'b1, '{we: 1, addr: 32'h300, be: 4'b1100, wdata: 32'hABCDABCD}, 32'h12345678, 32'h0);
    req_d(1'b1, 32'h302, 2'd1, 1'b0, 32'h0000ABCD);
    expect_txn(1'b1, '{we: 1, addr: 32'h100, be: 4'b0010, wdata: 32'h5A5A5A5A}, 32'h12345678, 32'h0);
    req_d(1'b1, 32'h101, 2'd0, 1'b0, 32'h0000005A);
    expect_txn(1'b1, '{we: 1, addr: 32'h404, be: 4'b1111, wdata: 32'h01234567}, 32'h12345678, 32'h0);
    req_d(1'b1, 32'h404, 2'd2, 1'b0, 32'h01234567);
    wait_idle();

    // Misaligned and reserved accesses: error grant, no memory traffic
    exp_gnt.push_back(2'b11);
    req_d(1'b0, 32'h401, 2'd2, 1'b0, 32'h0);
    exp_gnt.push_back(2'b11);
    req_d(1'b1, 32'h203, 2'd1, 1'b0, 32'h1234);
    exp_gnt.push_back(2'b11);
    req_d(1'b0, 32'h0, 2'd3, 1'b0, 32'h0);
    wait_idle();

    // Memory grant withheld for 5 cycles
    gnt_hold = 5;
    expect_txn(1'b0, '{we: 0, addr: 32'h500, be: 4'hF, wdata: 0}, 32'hCAFEF00D, 32'hCAFEF00D);
    req_if(32'h500);
    wait_idle();
    gnt_hold = 0;

    // Reset while waiting for the response, then a stray m_rvalid_i
    drop_rsp = 1;
    exp_gnt.push_back(2'b01);
    exp_mem.push_back('{we: 0, addr: 32'h600, be: 4'hF, wdata: 0});
    start_acc = acc_cnt;
    req_d(1'b0, 32'h600, 2'd2, 1'b0, 32'h0);
    for (int i = 0; i < 50 && acc_cnt == start_acc; i++) @(negedge clk_i);
    chk("rst_txn_accepted", 160'(acc_cnt - start_acc), 160'(1));
    @(negedge clk_i);
    rstn_i = 1'b0;
    #1 chk("reset_in_rsp_outputs", 160'(all_outs()), 160'(0));
    @(negedge clk_i);
    rstn_i   = 1'b1;
    drop_rsp = 0;
    #1 inject_rv = 1;
    @(negedge clk_i);
    #2 chk("rvalid_after_reset", 160'({if_rvalid_o, d_rvalid_o}), 160'(0));

    // Arbiter back in service after reset
    expect_txn(1'b0, '{we: 0, addr: 32'h700, be: 4'hF, wdata: 0}, 32'h0BADF00D, 32'h0BADF00D);
    req_if(32'h700);
    wait_idle();

    chk("queues_drained", 160'(exp_gnt.size() + exp_mem.size() + exp_rsp.size()), 160'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
